// File: rtl/ebox_mem_req_if.sv
`default_nettype none
// ============================================================================
// Module   : ebox_mem_req_if
// Purpose  : EBOX microcode control and mbox memory-port signals bundled for
//            the ebox_mem_req initiator.
// Revision : 1.0 - initial release
// ============================================================================
interface ebox_mem_req_if;
  // EBOX microcode control side
  logic        startRead;
  logic        startWrite;
  logic        startRPW;
  logic [22:0] vmaIn;
  logic        acRefIn;
  logic [35:0] wrData;
  logic        busy;
  logic [35:0] mb;
  logic        mbValid;
  logic        wrDone;
  logic        pageFail;
  logic        startErr;
  // mbox side
  logic [22:0] EBOX_VMA;
  logic        vmaACRef;
  logic        req;
  logic        read;
  logic        write;
  logic        PSE;
  logic [35:0] cacheDataWrite;
  logic [35:0] cacheDataRead;
  logic [10:0] pfDisp;

  modport master (
    input  startRead, startWrite, startRPW, vmaIn, acRefIn, wrData,
    input  cacheDataRead, pfDisp,
    output busy, mb, mbValid, wrDone, pageFail, startErr,
    output EBOX_VMA, vmaACRef, req, read, write, PSE, cacheDataWrite
  );

  modport slave (
    output startRead, startWrite, startRPW, vmaIn, acRefIn, wrData,
    output cacheDataRead, pfDisp,
    input  busy, mb, mbValid, wrDone, pageFail, startErr,
    input  EBOX_VMA, vmaACRef, req, read, write, PSE, cacheDataWrite
  );
endinterface
`default_nettype wire

// File: rtl/ebox_mem_req.sv
`default_nettype none
// ============================================================================
// Module   : ebox_mem_req
// Purpose  : EBOX-side initiator for the mbox memory port; issues read, write
//            and read-pause-write cycles timed by fixed latency.
// Revision : 1.0 - initial release
// ============================================================================
module ebox_mem_req #(
  parameter int READ_LAT  = 1,
  parameter int WRITE_LAT = 1
) (
  input  logic           eboxClk,
  input  logic           eboxRstN,
  ebox_mem_req_if.master bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    PAUSE   = 2'd2,
    WR_WAIT = 2'd3
  } state_t;

  // The read count covers the strobe cycle too, so capture lands READ_LAT
  // cycles after the strobe and mbValid one cycle later.
  localparam logic [4:0] c_rd_load = 5'(READ_LAT + 1);
  localparam logic [4:0] c_wr_load = 5'(WRITE_LAT);

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic        r_rpw;
  logic [35:0] r_mb;
  logic        r_mb_valid;
  logic        r_wr_done;
  logic        r_page_fail;
  logic        r_start_err;
  logic [22:0] r_vma;
  logic        r_ac_ref;
  logic        r_req;
  logic        r_read;
  logic        r_write;
  logic        r_pse;
  logic [35:0] r_cdw;

  logic w_busy;
  logic w_start_err;

  assign w_busy      = (r_state != IDLE) || r_req;
  assign w_start_err = w_busy && (bus.startRead || bus.startRPW ||
                                  (bus.startWrite && (r_state != PAUSE)));

  always_ff @(posedge eboxClk or negedge eboxRstN) begin
    if (!eboxRstN) begin
      r_state     <= IDLE;
      r_cnt       <= 5'd0;
      r_rpw       <= 1'b0;
      r_mb        <= 36'd0;
      r_mb_valid  <= 1'b0;
      r_wr_done   <= 1'b0;
      r_page_fail <= 1'b0;
      r_start_err <= 1'b0;
      r_vma       <= 23'd0;
      r_ac_ref    <= 1'b0;
      r_req       <= 1'b0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_pse       <= 1'b0;
      r_cdw       <= 36'd0;
    end else begin
      r_req       <= 1'b0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_mb_valid  <= 1'b0;
      r_wr_done   <= 1'b0;
      r_page_fail <= 1'b0;
      if (w_start_err) r_start_err <= 1'b1;

      case (r_state)
        IDLE: begin
          if (bus.startRPW || bus.startRead) begin
            r_vma    <= bus.vmaIn;
            r_ac_ref <= bus.acRefIn;
            r_req    <= 1'b1;
            r_read   <= 1'b1;
            r_pse    <= bus.startRPW;
            r_rpw    <= bus.startRPW;
            r_cnt    <= c_rd_load;
            r_state  <= RD_WAIT;
          end else if (bus.startWrite) begin
            r_vma    <= bus.vmaIn;
            r_ac_ref <= bus.acRefIn;
            r_cdw    <= bus.wrData;
            r_req    <= 1'b1;
            r_write  <= 1'b1;
            r_rpw    <= 1'b0;
            r_cnt    <= c_wr_load;
            r_state  <= WR_WAIT;
          end
        end
        RD_WAIT: begin
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            if (bus.pfDisp == 11'd0) begin
              r_mb       <= bus.cacheDataRead;
              r_mb_valid <= 1'b1;
              r_state    <= r_rpw ? PAUSE : IDLE;
            end else begin
              // A page fail abandons the whole RPW, so the pause ends here.
              r_page_fail <= 1'b1;
              r_pse       <= 1'b0;
              r_rpw       <= 1'b0;
              r_state     <= IDLE;
            end
          end
        end
        PAUSE: begin
          if (bus.startWrite) begin
            r_cdw   <= bus.wrData;
            r_req   <= 1'b1;
            r_write <= 1'b1;
            r_cnt   <= c_wr_load;
            r_state <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          // First WR_WAIT cycle is the strobe cycle; PSE falls right after it.
          r_pse <= 1'b0;
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_wr_done <= 1'b1;
            r_rpw     <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy           = w_busy;
  assign bus.mb             = r_mb;
  assign bus.mbValid        = r_mb_valid;
  assign bus.wrDone         = r_wr_done;
  assign bus.pageFail       = r_page_fail;
  assign bus.startErr       = r_start_err;
  assign bus.EBOX_VMA       = r_vma;
  assign bus.vmaACRef       = r_ac_ref;
  assign bus.req            = r_req;
  assign bus.read           = r_read;
  assign bus.write          = r_write;
  assign bus.PSE            = r_pse;
  assign bus.cacheDataWrite = r_cdw;
endmodule
`default_nettype wire

// File: tb/tb_ebox_mem_req.sv
`default_nettype none
// ============================================================================
// Module   : tb_ebox_mem_req
// Purpose  : Directed bench for ebox_mem_req with a cycle-schedule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ebox_mem_req;
  localparam int RL   = 1;
  localparam int WL   = 1;
  localparam int MAXC = 300;

  logic clk;
  logic rst_n;
  logic rst2_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   chk_en = 0;
  logic [10:0] pf;

  ebox_mem_req_if bus ();
  ebox_mem_req_if bus2 ();

  ebox_mem_req #(.READ_LAT(RL), .WRITE_LAT(WL)) dut (
    .eboxClk (clk), .eboxRstN(rst_n), .bus(bus));
  ebox_mem_req #(.READ_LAT(3), .WRITE_LAT(2)) dut2 (
    .eboxClk (clk), .eboxRstN(rst2_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mbox memory stand-in for dut
  logic [35:0] env_mem [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) env_mem[i] = 36'd0;
    env_mem[10'o1234] = 36'o123456701234;
    env_mem[10'o40]   = 36'd5;
    env_mem[10'o77]   = 36'o1111;
    forever begin
      @(posedge clk);
      if (bus.write === 1'b1) env_mem[bus.EBOX_VMA[9:0]] = bus.cacheDataWrite;
    end
  end
  always @(negedge clk) bus.cacheDataRead = env_mem[bus.EBOX_VMA[9:0]];
  assign bus.pfDisp = pf;

  // Model: expected outputs per cycle number
  bit          e_req [MAXC], e_read [MAXC], e_write [MAXC], e_mbv [MAXC], e_wrd [MAXC];
  bit          e_pf [MAXC], e_busy [MAXC], e_pse [MAXC], e_err [MAXC], e_acr [MAXC];
  logic [35:0] e_mb [MAXC], e_cdw [MAXC];
  logic [22:0] e_vma [MAXC];
  logic [35:0] mdl_mem [0:1023];
  bit          m_pause = 0;
  int          m_pause_from = 0;
  logic [22:0] m_addr = '0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic put(input int sel, input int a, input int b, input bit v);
    for (int i = a; i <= b && i < MAXC; i++)
      case (sel)
        0: e_busy[i] = v;
        1: e_pse[i]  = v;
        2: e_err[i]  = v;
        default: e_acr[i] = v;
      endcase
  endtask

  task automatic fill36(input int sel, input int c, input logic [35:0] v);
    for (int i = c; i < MAXC; i++)
      if (sel == 0) e_mb[i] = v; else e_cdw[i] = v;
  endtask

  task automatic fill_vma(input int c, input logic [22:0] v);
    for (int i = c; i < MAXC; i++) e_vma[i] = v;
  endtask

  // Start decided at the end of cycle k; its registered effects begin at k+1.
  task automatic model_start(input int k, input bit r, input bit w, input bit p,
                             input logic [22:0] a, input logic [35:0] d);
    int s;
    bit in_pause;
    s = k + 1;
    in_pause = m_pause && (k >= m_pause_from);
    if (e_busy[k]) begin
      if (in_pause && w) begin
        e_req[s] = 1; e_write[s] = 1;
        fill36(1, s, d);
        mdl_mem[m_addr[9:0]] = d;
        put(0, s + WL, MAXC - 1, 0);
        put(1, s + 1, MAXC - 1, 0);
        e_wrd[s + WL] = 1;
        m_pause = 0;
      end
      if (r || p || (w && !in_pause)) put(2, s, MAXC - 1, 1);
    end else if (r || p) begin
      e_req[s] = 1; e_read[s] = 1;
      fill_vma(s, a);
      put(3, s, MAXC - 1, a[3]);
      put(0, s, s + RL, 1);
      if (pf != 11'd0) begin
        e_pf[s + RL + 1] = 1;
        if (p) put(1, s, s + RL, 1);
      end else begin
        e_mbv[s + RL + 1] = 1;
        fill36(0, s + RL + 1, mdl_mem[a[9:0]]);
        if (p) begin
          put(0, s + RL + 1, MAXC - 1, 1);
          put(1, s, MAXC - 1, 1);
          m_pause = 1; m_pause_from = s + RL + 1; m_addr = a;
        end
      end
    end else if (w) begin
      e_req[s] = 1; e_write[s] = 1;
      fill_vma(s, a);
      put(3, s, MAXC - 1, a[3]);
      fill36(1, s, d);
      mdl_mem[a[9:0]] = d;
      put(0, s, s + WL - 1, 1);
      e_wrd[s + WL] = 1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      chk("req",      bus.req,            e_req[cyc]);
      chk("read",     bus.read,           e_read[cyc]);
      chk("write",    bus.write,          e_write[cyc]);
      chk("mbValid",  bus.mbValid,        e_mbv[cyc]);
      chk("wrDone",   bus.wrDone,         e_wrd[cyc]);
      chk("pageFail", bus.pageFail,       e_pf[cyc]);
      chk("busy",     bus.busy,           e_busy[cyc]);
      chk("PSE",      bus.PSE,            e_pse[cyc]);
      chk("startErr", bus.startErr,       e_err[cyc]);
      chk("mb",       bus.mb,             e_mb[cyc]);
      chk("EBOX_VMA", bus.EBOX_VMA,       e_vma[cyc]);
      chk("vmaACRef", bus.vmaACRef,       e_acr[cyc]);
      chk("cdWrite",  bus.cacheDataWrite, e_cdw[cyc]);
    end
  end

  task automatic do_start(input bit r, input bit w, input bit p, input logic [22:0] a,
                          input logic [35:0] d, output int k);
    @(negedge clk);
    k = cyc;
    bus.startRead = r; bus.startWrite = w; bus.startRPW = p;
    bus.vmaIn = a; bus.acRefIn = a[3]; bus.wrData = d;
    model_start(k, r, w, p, a, d);
    @(posedge clk);
    #1;
    bus.startRead = 0; bus.startWrite = 0; bus.startRPW = 0;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1);
  end

  initial begin
    int k, k2;
    for (int i = 0; i < MAXC; i++) begin
      e_mb[i] = '0; e_cdw[i] = '0; e_vma[i] = '0;
    end
    for (int i = 0; i < 1024; i++) mdl_mem[i] = 36'd0;
    mdl_mem[10'o1234] = 36'o123456701234;
    mdl_mem[10'o40]   = 36'd5;
    mdl_mem[10'o77]   = 36'o1111;
    pf = 11'd0;
    bus.startRead = 0; bus.startWrite = 0; bus.startRPW = 0;
    bus.vmaIn = '0; bus.acRefIn = 0; bus.wrData = '0;
    bus2.startRead = 0; bus2.startWrite = 0; bus2.startRPW = 0;
    bus2.vmaIn = '0; bus2.acRefIn = 0; bus2.wrData = '0;
    bus2.cacheDataRead = 36'o5252; bus2.pfDisp = '0;
    rst_n = 0; rst2_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mb", bus.mb, 0);
    chk("rst_err", bus.startErr, 0);
    chk("rst_strobes", {bus.req, bus.read, bus.write, bus.PSE}, 0);
    rst_n = 1; rst2_n = 1;
    chk_en = 1;
    repeat (2) @(negedge clk);

    // plain read
    do_start(1, 0, 0, 23'o1234, 36'd0, k);
    chk("lit_rd_strobe", {bus.req, bus.read}, 2'b11);
    wait_to(k + 3);
    chk("lit_rd_mbv", bus.mbValid, 1);
    chk("lit_rd_mb", bus.mb, 36'o123456701234);

    // write then read back
    do_start(0, 1, 0, 23'o20, 36'o777000111222, k);
    chk("lit_wr_strobe", bus.write, 1);
    wait_to(k + 2);
    chk("lit_wr_one_cycle", bus.write, 0);
    chk("lit_wr_done", bus.wrDone, 1);
    do_start(1, 0, 0, 23'o20, 36'd0, k);
    wait_to(k + 3);
    chk("lit_wr_rdback", bus.mb, 36'o777000111222);

    // read-pause-write
    do_start(0, 0, 1, 23'o40, 36'd0, k);
    wait_to(k + 3);
    chk("lit_rpw_mb", bus.mb, 36'd5);
    chk("lit_rpw_pse", bus.PSE, 1);
    wait_to(k + 4);
    do_start(0, 1, 0, 23'o77, 36'd6, k2);
    chk("lit_rpw_wr_vma", {bus.write, bus.EBOX_VMA}, {1'b1, 23'o40});
    wait_to(k2 + 2);
    chk("lit_rpw_pse_low", bus.PSE, 0);
    chk("lit_rpw_done", bus.wrDone, 1);
    do_start(1, 0, 0, 23'o77, 36'd0, k);
    wait_to(k + 3);
    chk("lit_rpw_77_kept", bus.mb, 36'o1111);
    do_start(1, 0, 0, 23'o40, 36'd0, k);
    wait_to(k + 3);
    chk("lit_rpw_40_new", bus.mb, 36'd6);

    // page fail aborts the RPW
    pf = 11'o7;
    do_start(0, 0, 1, 23'o1234, 36'd0, k);
    wait_to(k + 3);
    chk("lit_pf_pulse", bus.pageFail, 1);
    chk("lit_pf_mb", bus.mb, 36'd6);
    chk("lit_pf_pse", bus.PSE, 0);
    chk("lit_pf_idle", bus.busy, 0);
    pf = 11'd0;
    wait_to(k + 5);

    // simultaneous read and write: read wins
    do_start(1, 1, 0, 23'o20, 36'o55, k);
    chk("lit_prio", {bus.read, bus.write}, 2'b10);
    wait_to(k + 3);

    // start while busy is ignored and sticks startErr
    do_start(1, 0, 0, 23'o1234, 36'd0, k);
    do_start(1, 0, 0, 23'o20, 36'd0, k2);
    chk("lit_err_set", bus.startErr, 1);
    wait_to(k + 8);
    chk("lit_err_sticky", bus.startErr, 1);
    chk("lit_err_ignored", bus.mb, 36'o123456701234);

    // second instance: READ_LAT=3 latency, then reset mid-read
    @(negedge clk);
    k = cyc;
    bus2.startRead = 1; bus2.vmaIn = 23'o300;
    @(posedge clk);
    #1;
    bus2.startRead = 0;
    chk("d2_strobe", {bus2.req, bus2.read, bus2.busy}, 3'b111);
    wait_to(k + 4);
    chk("d2_mbv_early", bus2.mbValid, 0);
    wait_to(k + 5);
    chk("d2_mbv", bus2.mbValid, 1);
    chk("d2_mb", bus2.mb, 36'o5252);
    chk("d2_vma", bus2.EBOX_VMA, 23'o300);

    bus2.cacheDataRead = 36'o1717;
    @(negedge clk);
    k = cyc;
    bus2.startRead = 1; bus2.vmaIn = 23'o301;
    @(posedge clk);
    #1;
    bus2.startRead = 0;
    chk("d2r_strobe", bus2.read, 1);
    wait_to(k + 2);
    rst2_n = 0;
    #1;
    chk("d2r_strobes", {bus2.req, bus2.read, bus2.write, bus2.PSE}, 0);
    chk("d2r_busy", bus2.busy, 0);
    chk("d2r_mb", bus2.mb, 0);
    chk("d2r_vma", bus2.EBOX_VMA, 0);
    chk("d2r_misc", {bus2.mbValid, bus2.wrDone, bus2.pageFail, bus2.startErr, bus2.vmaACRef}, 0);
    @(negedge clk);
    rst2_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("d2r_no_mbv", {bus2.mbValid, bus2.mb}, 0);
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
